// File: rtl/prio_encoder_seq.sv
// One-deep registered priority encoder with valid/ready handshakes on both sides.
// Optional multi-hot flag on port err, enabled by defining ONEHOT_CHECK_EN.
module prio_encoder_seq #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:N-1]  w,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] idx,
  output logic          none,
  output logic          out_valid,
`ifdef ONEHOT_CHECK_EN
  output logic          err,
`endif
  input  logic          out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, enc_idx;
  logic          none_q, none_d, enc_none;
  logic          in_xfer, out_xfer;

  // Lowest set request wins; scanning downward lets lower indices overwrite.
  always_comb begin
    enc_idx  = '0;
    enc_none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (w[i]) begin
        enc_idx  = IW'(i);
        enc_none = 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign out_valid = (state_q == FULL);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign idx       = idx_q;
  assign none      = none_q;

  // Next state and result capture; a simultaneous in/out transfer refills without a bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    none_d  = none_q;
    case (state_q)
      EMPTY: if (in_xfer) state_d = FULL;
      FULL:  if (out_xfer && !in_xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (in_xfer) begin
      idx_d  = enc_idx;
      none_d = enc_none;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic multi_hot, seen_bit;
  logic err_q, err_d;

  // Flags two or more asserted request lines.
  always_comb begin
    multi_hot = 1'b0;
    seen_bit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) begin
        if (seen_bit) multi_hot = 1'b1;
        seen_bit = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (in_xfer) err_d = multi_hot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Bench for prio_encoder_seq: vector table, hand sequences for handshake corners,
// and random traffic against a one-entry buffer model.
module tb_prio_encoder_seq;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:N-1]  w;
  logic          in_valid, in_ready, none, out_valid, out_ready;
  logic [IW-1:0] idx;
`ifdef ONEHOT_CHECK_EN
  logic          err;
`endif

  prio_encoder_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .w(w), .in_valid(in_valid), .in_ready(in_ready),
    .idx(idx), .none(none), .out_valid(out_valid),
`ifdef ONEHOT_CHECK_EN
    .err(err),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference: a single result slot
  bit m_have;
  int m_idx, m_none, m_err;

  typedef struct {
    logic [0:N-1] wv;
    int           e_idx;
    int           e_none;
    int           e_err;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_idx = 0; m_none = 0; m_err = 0;
  endtask

  // Expected result from request vector via arithmetic on an integer view of w.
  task automatic model_edge(input logic [0:N-1] wv, input bit iv, input bit ordy);
    int r;
    bit acc;
    r = 0;
    for (int i = 0; i < N; i++) if (wv[i]) r = r | (1 << i);
    acc = iv && (!m_have || ordy);
    if (acc) begin
      m_have = 1;
      m_none = (r == 0) ? 1 : 0;
      m_idx  = (r == 0) ? 0 : $clog2(r & -r);
      m_err  = ($countones(r) >= 2) ? 1 : 0;
    end else if (m_have && ordy) begin
      m_have = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), int'(m_have));
    chk({tag, ".idx"}, int'(idx), m_idx);
    chk({tag, ".none"}, int'(none), m_none);
`ifdef ONEHOT_CHECK_EN
    chk({tag, ".err"}, int'(err), m_err);
`endif
  endtask

  // Called at posedge+1: drive, check in_ready, cross one edge, check outputs.
  task automatic step(input logic [0:N-1] wv, input bit iv, input bit ordy, input string tag);
    w = wv; in_valid = iv; out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, int'(in_ready), int'(!m_have || ordy));
    model_edge(wv, iv, ordy);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    vecs[0] = '{4'b1000, 0, 0, 0};
    vecs[1] = '{4'b0100, 1, 0, 0};
    vecs[2] = '{4'b0010, 2, 0, 0};
    vecs[3] = '{4'b0001, 3, 0, 0};
    vecs[4] = '{4'b0110, 1, 0, 1};
    vecs[5] = '{4'b0000, 0, 1, 0};

    rst_n = 1'b0; w = '0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.idx", int'(idx), 0);
    chk("reset.none", int'(none), 0);
    chk("reset.in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors, one per cycle with out_ready high
    for (int k = 0; k < 6; k++) begin
      step(vecs[k].wv, 1'b1, 1'b1, "vec");
      chk("vec.tbl_idx", int'(idx), vecs[k].e_idx);
      chk("vec.tbl_none", int'(none), vecs[k].e_none);
      chk("vec.tbl_valid", int'(out_valid), 1);
`ifdef ONEHOT_CHECK_EN
      chk("vec.tbl_err", int'(err), vecs[k].e_err);
`endif
    end
    step(4'b0000, 1'b0, 1'b1, "drain");
    chk("drain.valid", int'(out_valid), 0);
    step(4'b0100, 1'b0, 1'b1, "idle");
    chk("idle.idx_hold", int'(idx), 0);
    chk("idle.none_hold", int'(none), 1);

    // Backpressure: held result stays while a new request waits
    step(4'b0010, 1'b1, 1'b1, "bp_load");
    for (int k = 0; k < 3; k++) begin
      w = 4'b0001; in_valid = 1'b1; out_ready = 1'b0; #1;
      chk("bp.in_ready_low", int'(in_ready), 0);
      step(4'b0001, 1'b1, 1'b0, "bp_hold");
      chk("bp.idx_held", int'(idx), 2);
      chk("bp.valid_held", int'(out_valid), 1);
    end
    step(4'b0001, 1'b1, 1'b1, "bp_release");
    chk("bp.idx_new", int'(idx), 3);
    chk("bp.valid_cont", int'(out_valid), 1);
    step(4'b0000, 1'b0, 1'b1, "bp_drain");

    // Streaming: 8 back-to-back transfers
    for (int k = 0; k < 8; k++) begin
      logic [0:N-1] sv;
      sv = '0;
      sv[k % N] = 1'b1;
      step(sv, 1'b1, 1'b1, "stream");
      chk("stream.idx_order", int'(idx), k % N);
      chk("stream.valid", int'(out_valid), 1);
    end
    step(4'b0000, 1'b0, 1'b1, "stream_drain");

    // Asynchronous reset while FULL, no clock edge involved
    step(4'b0001, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst.full", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.idx", int'(idx), 0);
    chk("arst.none", int'(none), 0);
    chk("arst.in_ready", int'(in_ready), 1);
`ifdef ONEHOT_CHECK_EN
    chk("arst.err", int'(err), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(4'b0000, 1'b0, 1'b1, "post_rst");
    chk("post_rst.no_valid", int'(out_valid), 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [0:N-1] rv;
      rv = N'($urandom_range(0, (1 << N) - 1));
      step(rv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/prio_encoder_seq.md
PRIO_ENCODER_SEQ -- requirements
Module: prio_encoder_seq

Interface
REQ-001 Parameter N, default 4, meaning number of request lines; SHALL be a power of two in 2..16.
REQ-002 Parameter IW, default $clog2(N), meaning encoded index width; SHALL NOT be overridden.
REQ-003 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port w  in  [0:N-1]  request vector; w[i] requests index i, so the ordering matches the decoder's y[0:N-1].
REQ-006 Port in_valid  in  1  w is valid this cycle.
REQ-007 Port in_ready  out  1  block accepts w this cycle.
REQ-008 Port idx  out  [IW-1:0]  registered encoded index.
REQ-009 Port none  out  1  registered; the accepted w was all zeros.
REQ-010 Port out_valid  out  1  idx/none hold a result.
REQ-011 Port out_ready  in  1  consumer takes the result this cycle.
REQ-012 Port err  out  1  registered multi-hot flag; present only with ONEHOT_CHECK_EN (REQ-027).

Function
REQ-013 Priority: idx SHALL equal the lowest i with w[i]=1; w all-zero SHALL give idx=0 and none=1.
REQ-014 Accept: a transfer in SHALL occur on an edge where in_valid=1 and in_ready=1; the result SHALL be registered on that edge, giving 1-cycle latency.
REQ-015 Output transfer: this SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL be combinational: (state==EMPTY) or out_ready.
REQ-017 FSM states SHALL be EMPTY and FULL; out_valid SHALL be 1 exactly in FULL.
REQ-018 EMPTY to FULL SHALL occur on an input transfer.
REQ-019 FULL to EMPTY SHALL occur on an output transfer with no simultaneous input transfer.
REQ-020 FULL with simultaneous input and output transfers SHALL stay FULL, and idx/none SHALL load the new result on that edge with no bubble.
REQ-021 While FULL and out_ready=0, idx, none, err and out_valid SHALL hold stable and w SHALL be ignored.
REQ-022 in_valid=0 in EMPTY SHALL cause no state change; idx/none SHALL keep their last values.
REQ-023 Throughput SHALL be one result per cycle when out_ready stays 1.

Reset
REQ-024 On rst_n low, state SHALL go to EMPTY immediately (asynchronously), with out_valid=0, idx=0, none=0, err=0.
REQ-025 Reset mid-operation SHALL discard any held result; no output transfer SHALL occur on the edge where rst_n is released.
REQ-026 in_ready SHALL be 1 during reset and after it, because state is EMPTY.

Configuration
REQ-027 Macro ONEHOT_CHECK_EN SHALL control the multi-hot check; with it defined, port err SHALL exist and be registered with the result, err=1 when the accepted w has two or more bits set, err=0 otherwise.
REQ-028 Without ONEHOT_CHECK_EN, port err and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset: assert rst_n=0 mid-FULL with no clock -> out_valid=0, idx=0, none=0 at once; in_ready=1.
REQ-030 Single requests (N=4): w=1000, 0100, 0010, 0001 with out_ready=1 -> idx=0, 1, 2, 3 one cycle after each, none=0.
REQ-031 Priority and zero: w=0110 -> idx=1 (err=1 if ONEHOT_CHECK_EN); w=0000 -> idx=0, none=1, err=0.
REQ-032 Backpressure: accept w=0010, hold out_ready=0 for 3 cycles while w=0001 is offered -> in_ready=0, idx stays 2; then out_ready=1 -> w=0001 accepted the same edge, idx=3 next cycle, out_valid continuously 1.
REQ-033 Streaming: 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles, in order, out_valid never drops.
REQ-034 Build both with and without ONEHOT_CHECK_EN -> identical idx/none/out_valid traces for the same stimulus.
